// File: rtl/gen_bst_sorter_v2_if.sv
// Producer/consumer bus of gen_bst_sorter_v2: insert handshake, min/max
// taps and the ready-backpressured extract stream.
interface gen_bst_sorter_v2_if #(
  parameter int KEY_W        = 8,
  parameter int VALUE_W      = 16,
  parameter int MAX_ELEM_NUM = 32
);
  localparam int MAX_ELEM_NUM_IDX_W = $clog2(MAX_ELEM_NUM);

  // Insert side
  logic                          new_elem_valid;
  logic [KEY_W-1:0]              new_elem_key;
  logic [VALUE_W-1:0]            new_elem_value;
  logic                          new_elem_ack;
  logic                          sort_is_done_pls;

  // Running extremes of the stored batch
  logic [KEY_W-1:0]              min_elem_key;
  logic [VALUE_W-1:0]            min_elem_value;
  logic [KEY_W-1:0]              max_elem_key;
  logic [VALUE_W-1:0]            max_elem_value;

  // Extract side
  logic                          get_all_sorted_data_req_pls;
  logic                          get_elem_ready;
  logic                          get_all_sorted_data_done_lvl;
  logic [MAX_ELEM_NUM_IDX_W-1:0] get_elem_idx;
  logic                          get_elem_valid;
  logic [KEY_W-1:0]              get_elem_key;
  logic [VALUE_W-1:0]            get_elem_value;

  // Producer and consumer of sorted data
  modport master (
    output new_elem_valid, new_elem_key, new_elem_value,
    output get_all_sorted_data_req_pls, get_elem_ready,
    input  new_elem_ack, sort_is_done_pls,
    input  min_elem_key, min_elem_value, max_elem_key, max_elem_value,
    input  get_all_sorted_data_done_lvl, get_elem_idx, get_elem_valid,
    input  get_elem_key, get_elem_value
  );

  // The sorter itself
  modport slave (
    input  new_elem_valid, new_elem_key, new_elem_value,
    input  get_all_sorted_data_req_pls, get_elem_ready,
    output new_elem_ack, sort_is_done_pls,
    output min_elem_key, min_elem_value, max_elem_key, max_elem_value,
    output get_all_sorted_data_done_lvl, get_elem_idx, get_elem_valid,
    output get_elem_key, get_elem_value
  );
endinterface

// File: rtl/gen_bst_sorter_v2.sv
// Insertion sorter: keeps up to MAX_ELEM_NUM key/value pairs ordered in a
// register array (ascending or descending, stable for equal keys), tracks
// min/max, and replays the sorted batch over a valid/ready stream.
module gen_bst_sorter_v2 #(
  parameter  int KEY_W              = 8,
  parameter  int VALUE_W            = 16,
  parameter  int MAX_ELEM_NUM       = 32,
  parameter  int SIM_DLY            = 1,
  localparam int MAX_ELEM_NUM_W     = $clog2(MAX_ELEM_NUM + 1),
  localparam int MAX_ELEM_NUM_IDX_W = $clog2(MAX_ELEM_NUM)
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      sw_rst,
  input  logic [MAX_ELEM_NUM_W-1:0] i_cnfg_elems_num,
  input  logic                      i_cnfg_descend,
  input  logic                      i_enable,
  output logic                      o_sorter_phase,
  output logic [MAX_ELEM_NUM_W-1:0] o_elems_cnt,
  gen_bst_sorter_v2_if.slave        bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_INSERT = 2'd1,
    S_SORTED = 2'd2,
    S_STREAM = 2'd3
  } state_e;

  typedef logic [KEY_W-1:0]              key_t;
  typedef logic [VALUE_W-1:0]            value_t;
  typedef logic [MAX_ELEM_NUM_W-1:0]     cnt_t;
  typedef logic [MAX_ELEM_NUM_IDX_W-1:0] idx_t;

  // SIM_DLY is kept so existing instantiations still elaborate; the
  // register outputs here carry no modelled delay.
  if (SIM_DLY < 0) begin : g_sim_dly_unused
  end

  state_e state_q, state_d;
  key_t   key_q [MAX_ELEM_NUM];
  key_t   key_d [MAX_ELEM_NUM];
  value_t val_q [MAX_ELEM_NUM];
  value_t val_d [MAX_ELEM_NUM];
  cnt_t   cnt_q, cnt_d;
  logic   ack_q, ack_d;
  logic   done_pls_q, done_pls_d;
  logic   valid_q, valid_d;
  logic   done_lvl_q, done_lvl_d;
  idx_t   idx_q, idx_d;
  key_t   min_key_q, min_key_d, max_key_q, max_key_d;
  value_t min_val_q, min_val_d, max_val_q, max_val_d;

  // Array contents if the element on the bus were inserted this cycle
  key_t   ins_key [MAX_ELEM_NUM];
  value_t ins_val [MAX_ELEM_NUM];
  logic [MAX_ELEM_NUM-1:0] beyond;

  cnt_t n_eff;
  logic insert_fire;
  logic last_beat;
  logic new_is_min;
  logic new_is_max;

  // Batch size, clamped to the array depth
  assign n_eff = (i_cnfg_elems_num > cnt_t'(MAX_ELEM_NUM)) ? cnt_t'(MAX_ELEM_NUM)
                                                           : i_cnfg_elems_num;

  // Per-slot compare against the incoming key and the shifted array.
  // A slot is "beyond" the new key when it is occupied and strictly after it
  // in sort order; since the array is sorted those slots form a contiguous
  // tail, so the new element lands at the first beyond slot (or at cnt when
  // none is) and every beyond slot moves up by one. Equal keys are never
  // beyond, which keeps arrival order among them.
  for (genvar g = 0; g < MAX_ELEM_NUM; g++) begin : g_slot
    logic   take_prev;
    key_t   prev_key;
    value_t prev_val;

    if (g == 0) begin : g_first
      assign take_prev = 1'b0;
      assign prev_key  = '0;
      assign prev_val  = '0;
    end else begin : g_rest
      assign take_prev = beyond[g-1];
      assign prev_key  = key_q[g-1];
      assign prev_val  = val_q[g-1];
    end

    assign beyond[g] = (cnt_t'(g) < cnt_q) &&
                       (i_cnfg_descend ? (key_q[g] < bus.new_elem_key)
                                       : (key_q[g] > bus.new_elem_key));

    assign ins_key[g] = take_prev ? prev_key :
                        ((beyond[g] || (cnt_t'(g) == cnt_q)) ? bus.new_elem_key : key_q[g]);
    assign ins_val[g] = take_prev ? prev_val :
                        ((beyond[g] || (cnt_t'(g) == cnt_q)) ? bus.new_elem_value : val_q[g]);
  end

  // Handshake qualifiers and extreme tracking (strict compares keep the
  // first-arrived element among equal extremes)
  assign insert_fire = (state_q == S_INSERT) && bus.new_elem_valid && !ack_q &&
                       (cnt_q < n_eff);
  assign last_beat   = (cnt_t'(idx_q) == (cnt_q - cnt_t'(1)));
  assign new_is_min  = (cnt_q == '0) || (bus.new_elem_key < min_key_q);
  assign new_is_max  = (cnt_q == '0) || (bus.new_elem_key > max_key_q);

  // Next-state and datapath: clear, insert, and extract sequencing
  always_comb begin
    // NOTE: every variable gets its hold/default value before any branch;
    // otherwise a path that skips the assignment would infer a latch.
    state_d    = state_q;
    key_d      = key_q;
    val_d      = val_q;
    cnt_d      = cnt_q;
    ack_d      = 1'b0;
    done_pls_d = 1'b0;
    valid_d    = valid_q;
    idx_d      = idx_q;
    done_lvl_d = done_lvl_q;
    min_key_d  = min_key_q;
    min_val_d  = min_val_q;
    max_key_d  = max_key_q;
    max_val_d  = max_val_q;

    if (sw_rst || !i_enable) begin
      state_d    = S_IDLE;
      key_d      = '{default: '0};
      val_d      = '{default: '0};
      cnt_d      = '0;
      valid_d    = 1'b0;
      idx_d      = '0;
      done_lvl_d = 1'b0;
      min_key_d  = '0;
      min_val_d  = '0;
      max_key_d  = '0;
      max_val_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (n_eff == '0) begin
            state_d    = S_SORTED;
            done_pls_d = 1'b1;
          end else begin
            state_d = S_INSERT;
          end
        end

        S_INSERT: begin
          if (insert_fire) begin
            key_d = ins_key;
            val_d = ins_val;
            cnt_d = cnt_q + cnt_t'(1);
            ack_d = 1'b1;
            if (new_is_min) begin
              min_key_d = bus.new_elem_key;
              min_val_d = bus.new_elem_value;
            end
            if (new_is_max) begin
              max_key_d = bus.new_elem_key;
              max_val_d = bus.new_elem_value;
            end
            if ((cnt_q + cnt_t'(1)) == n_eff) begin
              state_d    = S_SORTED;
              done_pls_d = 1'b1;
            end
          end
        end

        S_SORTED: begin
          if (bus.get_all_sorted_data_req_pls) begin
            if (cnt_q == '0) begin
              // Empty batch: extraction is complete without any beat
              done_lvl_d = 1'b1;
            end else begin
              state_d    = S_STREAM;
              idx_d      = '0;
              valid_d    = 1'b1;
              done_lvl_d = 1'b0;
            end
          end
        end

        S_STREAM: begin
          if (bus.get_elem_ready) begin
            if (last_beat) begin
              state_d    = S_SORTED;
              valid_d    = 1'b0;
              idx_d      = '0;
              done_lvl_d = 1'b1;
            end else begin
              idx_d = idx_q + idx_t'(1);
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, array and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      // NOTE: the storage array is reset on purpose: the streamed data and
      // min/max outputs must read 0 after reset, not stale contents.
      key_q      <= '{default: '0};
      val_q      <= '{default: '0};
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      done_pls_q <= 1'b0;
      valid_q    <= 1'b0;
      idx_q      <= '0;
      done_lvl_q <= 1'b0;
      min_key_q  <= '0;
      min_val_q  <= '0;
      max_key_q  <= '0;
      max_val_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers update from the
      // same pre-edge values regardless of statement order.
      state_q    <= state_d;
      key_q      <= key_d;
      val_q      <= val_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      done_pls_q <= done_pls_d;
      valid_q    <= valid_d;
      idx_q      <= idx_d;
      done_lvl_q <= done_lvl_d;
      min_key_q  <= min_key_d;
      min_val_q  <= min_val_d;
      max_key_q  <= max_key_d;
      max_val_q  <= max_val_d;
    end
  end

  assign o_sorter_phase                   = (state_q == S_SORTED) || (state_q == S_STREAM);
  assign o_elems_cnt                      = cnt_q;
  assign bus.new_elem_ack                 = ack_q;
  assign bus.sort_is_done_pls             = done_pls_q;
  assign bus.min_elem_key                 = min_key_q;
  assign bus.min_elem_value               = min_val_q;
  assign bus.max_elem_key                 = max_key_q;
  assign bus.max_elem_value               = max_val_q;
  assign bus.get_all_sorted_data_done_lvl = done_lvl_q;
  assign bus.get_elem_idx                 = idx_q;
  assign bus.get_elem_valid               = valid_q;
  assign bus.get_elem_key                 = valid_q ? key_q[idx_q] : '0;
  assign bus.get_elem_value               = valid_q ? val_q[idx_q] : '0;

endmodule

// File: tb/tb_gen_bst_sorter_v2.sv
// Bench for gen_bst_sorter_v2: directed scenarios plus randomized batches
// compared against a queue-based stable-sort reference.
module tb_gen_bst_sorter_v2;
  localparam int KEY_W        = 8;
  localparam int VALUE_W      = 16;
  localparam int MAX_ELEM_NUM = 32;
  localparam int CNT_W        = $clog2(MAX_ELEM_NUM + 1);

  logic             clk = 1'b0;
  logic             rstn;
  logic             sw_rst;
  logic [CNT_W-1:0] i_cnfg_elems_num;
  logic             i_cnfg_descend;
  logic             i_enable;
  logic             o_sorter_phase;
  logic [CNT_W-1:0] o_elems_cnt;

  gen_bst_sorter_v2_if #(
    .KEY_W(KEY_W), .VALUE_W(VALUE_W), .MAX_ELEM_NUM(MAX_ELEM_NUM)
  ) bus ();

  gen_bst_sorter_v2 #(
    .KEY_W(KEY_W), .VALUE_W(VALUE_W), .MAX_ELEM_NUM(MAX_ELEM_NUM), .SIM_DLY(1)
  ) dut (
    .clk              (clk),
    .rstn             (rstn),
    .sw_rst           (sw_rst),
    .i_cnfg_elems_num (i_cnfg_elems_num),
    .i_cnfg_descend   (i_cnfg_descend),
    .i_enable         (i_enable),
    .o_sorter_phase   (o_sorter_phase),
    .o_elems_cnt      (o_elems_cnt),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [KEY_W-1:0]   key;
    logic [VALUE_W-1:0] value;
  } elem_t;

  int    n_checks = 0;
  int    n_errors = 0;
  elem_t arrivals[$];
  elem_t sorted_exp[$];
  int    exp_n;
  bit    cur_desc;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: stable sort of the arrival list (swap only strictly out-of-order pairs)
  function automatic void build_expected(input bit desc);
    elem_t t;
    bit    swap;
    sorted_exp = arrivals;
    for (int p = 0; p < sorted_exp.size(); p++) begin
      for (int j = 0; j + 1 < sorted_exp.size() - p; j++) begin
        swap = desc ? (sorted_exp[j].key < sorted_exp[j+1].key)
                    : (sorted_exp[j].key > sorted_exp[j+1].key);
        if (swap) begin
          t               = sorted_exp[j];
          sorted_exp[j]   = sorted_exp[j+1];
          sorted_exp[j+1] = t;
        end
      end
    end
  endfunction

  // Reference extremes: first arrival among equal keys wins
  task automatic check_minmax();
    elem_t mn, mx;
    mn = '0;
    mx = '0;
    for (int i = 0; i < arrivals.size(); i++) begin
      if (i == 0 || arrivals[i].key < mn.key) mn = arrivals[i];
      if (i == 0 || arrivals[i].key > mx.key) mx = arrivals[i];
    end
    check("min_key", bus.min_elem_key, mn.key);
    check("min_val", bus.min_elem_value, mn.value);
    check("max_key", bus.max_elem_key, mx.key);
    check("max_val", bus.max_elem_value, mx.value);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_cnt"},      o_elems_cnt, 0);
    check({tag, "_phase"},    o_sorter_phase, 0);
    check({tag, "_ack"},      bus.new_elem_ack, 0);
    check({tag, "_done_pls"}, bus.sort_is_done_pls, 0);
    check({tag, "_min"},      {bus.min_elem_key, bus.min_elem_value}, 0);
    check({tag, "_max"},      {bus.max_elem_key, bus.max_elem_value}, 0);
    check({tag, "_valid"},    bus.get_elem_valid, 0);
    check({tag, "_done_lvl"}, bus.get_all_sorted_data_done_lvl, 0);
    check({tag, "_idx"},      bus.get_elem_idx, 0);
    check({tag, "_data"},     {bus.get_elem_key, bus.get_elem_value}, 0);
  endtask

  // Clears via i_enable=0, then enables a new batch of n elements
  task automatic start_batch(input int n, input bit desc);
    i_enable = 1'b0;
    @(posedge clk); #1;
    check("clr_cnt", o_elems_cnt, 0);
    check("clr_phase", o_sorter_phase, 0);
    arrivals.delete();
    cur_desc         = desc;
    exp_n            = (n > MAX_ELEM_NUM) ? MAX_ELEM_NUM : n;
    i_cnfg_elems_num = CNT_W'(n);
    i_cnfg_descend   = desc;
    i_enable         = 1'b1;
    @(posedge clk); #1;
    check("start_phase", o_sorter_phase, exp_n == 0);
    check("start_done", bus.sort_is_done_pls, exp_n == 0);
  endtask

  // One insert: ack expected exactly one cycle after valid, for one cycle
  task automatic insert_elem(input logic [KEY_W-1:0] k, input logic [VALUE_W-1:0] v);
    elem_t e;
    int    gap;
    bus.new_elem_valid = 1'b1;
    bus.new_elem_key   = k;
    bus.new_elem_value = v;
    @(posedge clk); #1;
    bus.new_elem_valid = 1'b0;
    e.key   = k;
    e.value = v;
    arrivals.push_back(e);
    check("ack", bus.new_elem_ack, 1);
    check("cnt", o_elems_cnt, arrivals.size());
    check("done_pls", bus.sort_is_done_pls, arrivals.size() == exp_n);
    check("phase", o_sorter_phase, arrivals.size() == exp_n);
    check_minmax();
    @(posedge clk); #1;
    check("ack_one_cycle", bus.new_elem_ack, 0);
    check("done_one_cycle", bus.sort_is_done_pls, 0);
    gap = $urandom_range(0, 2);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic try_ignored_insert();
    bus.new_elem_valid = 1'b1;
    bus.new_elem_key   = KEY_W'($urandom);
    bus.new_elem_value = VALUE_W'($urandom);
    repeat (2) begin
      @(posedge clk); #1;
      check("ign_ack", bus.new_elem_ack, 0);
      check("ign_cnt", o_elems_cnt, arrivals.size());
    end
    bus.new_elem_valid = 1'b0;
  endtask

  // Request + full extraction; ready dropped at stall_at for stall_len
  // cycles and, optionally, randomly elsewhere
  task automatic stream_check(input int stall_at, input int stall_len, input bit rand_rdy);
    int e       = 0;
    int stalled = 0;
    int budget  = 0;
    bit rdy;
    build_expected(cur_desc);
    bus.get_all_sorted_data_req_pls = 1'b1;
    @(posedge clk); #1;
    bus.get_all_sorted_data_req_pls = 1'b0;
    while (e < exp_n && budget < 2000) begin
      rdy = 1'b1;
      if (rand_rdy) rdy = ($urandom_range(0, 3) != 0);
      if (e == stall_at && stalled < stall_len) begin
        rdy = 1'b0;
        stalled++;
      end
      bus.get_elem_ready = rdy;
      check("s_valid", bus.get_elem_valid, 1);
      check("s_idx", bus.get_elem_idx, e);
      check("s_key", bus.get_elem_key, sorted_exp[e].key);
      check("s_val", bus.get_elem_value, sorted_exp[e].value);
      check("s_done_lvl", bus.get_all_sorted_data_done_lvl, 0);
      @(posedge clk); #1;
      if (rdy) e++;
      budget++;
    end
    bus.get_elem_ready = 1'b1;
    check("s_beats", e, exp_n);
    check("s_end_valid", bus.get_elem_valid, 0);
    check("s_end_done", bus.get_all_sorted_data_done_lvl, 1);
    check("s_end_data", {bus.get_elem_key, bus.get_elem_value}, 0);
    check("s_end_phase", o_sorter_phase, 1);
  endtask

  int dk[8] = '{5, 10, 4, 10, 2, 100, 20, 1};

  initial begin
    int n;
    rstn = 1'b1;
    sw_rst = 1'b0;
    i_enable = 1'b0;
    i_cnfg_elems_num = '0;
    i_cnfg_descend = 1'b0;
    bus.new_elem_valid = 1'b0;
    bus.new_elem_key = '0;
    bus.new_elem_value = '0;
    bus.get_all_sorted_data_req_pls = 1'b0;
    bus.get_elem_ready = 1'b1;
    #2 rstn = 1'b0;
    #10;
    check_cleared("reset");
    rstn = 1'b1;
    @(posedge clk); #1;

    // Ascending N=8, then backpressured replay, then plain replay
    start_batch(8, 1'b0);
    for (int i = 0; i < 8; i++) insert_elem(KEY_W'(dk[i]), VALUE_W'(i + 1));
    try_ignored_insert();
    stream_check(-1, 0, 1'b0);
    stream_check(3, 3, 1'b0);
    stream_check(-1, 0, 1'b0);

    // Same inputs, descending
    start_batch(8, 1'b1);
    for (int i = 0; i < 8; i++) insert_elem(KEY_W'(dk[i]), VALUE_W'(i + 1));
    stream_check(-1, 0, 1'b0);

    // Clamp of N above depth
    start_batch(40, 1'($urandom));
    for (int i = 0; i < MAX_ELEM_NUM; i++)
      insert_elem(KEY_W'($urandom_range(0, 20)), VALUE_W'($urandom));
    try_ignored_insert();
    stream_check(-1, 0, 1'b1);

    // Empty batch
    start_batch(0, 1'b0);
    @(posedge clk); #1;
    check("n0_done_drop", bus.sort_is_done_pls, 0);
    stream_check(-1, 0, 1'b0);

    // Request during INSERT is ignored; sw_rst after the 3rd insert clears all
    start_batch(8, 1'b0);
    bus.get_all_sorted_data_req_pls = 1'b1;
    @(posedge clk); #1;
    bus.get_all_sorted_data_req_pls = 1'b0;
    check("ins_req_valid", bus.get_elem_valid, 0);
    check("ins_req_phase", o_sorter_phase, 0);
    for (int i = 0; i < 3; i++) insert_elem(KEY_W'(dk[i]), VALUE_W'(i + 1));
    sw_rst = 1'b1;
    @(posedge clk); #1;
    sw_rst = 1'b0;
    check_cleared("sw_rst");

    // i_enable=0 while idx 4 is presented
    start_batch(8, 1'b0);
    for (int i = 0; i < 8; i++) insert_elem(KEY_W'($urandom), VALUE_W'($urandom));
    bus.get_all_sorted_data_req_pls = 1'b1;
    @(posedge clk); #1;
    bus.get_all_sorted_data_req_pls = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("abort_idx", bus.get_elem_idx, 4);
    check("abort_valid_before", bus.get_elem_valid, 1);
    i_enable = 1'b0;
    @(posedge clk); #1;
    check_cleared("abort");

    // Asynchronous reset between edges
    start_batch(8, 1'b0);
    for (int i = 0; i < 5; i++) insert_elem(KEY_W'(dk[i]), VALUE_W'(i + 1));
    #2 rstn = 1'b0;
    #1;
    check_cleared("async_rst");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Randomized batches with duplicate-heavy keys and random backpressure
    repeat (6) begin
      n = $urandom_range(1, MAX_ELEM_NUM);
      start_batch(n, 1'($urandom));
      for (int i = 0; i < n; i++)
        insert_elem(KEY_W'($urandom_range(0, 15)), VALUE_W'($urandom));
      try_ignored_insert();
      stream_check(-1, 0, 1'b1);
      stream_check($urandom_range(0, n - 1), $urandom_range(1, 3), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
